sram_arb: RTL

Access sequencer and arbiter for the external 16-bit asynchronous waveform/histogram SRAM. It serves three requesters over the single SRAM port:
- an internal clear engine that sweeps the memory to zero;
- a pulse-height histogram port that does read-modify-write increments;
- a USB readout port that does single-word reads.

The block generates all SRAM strobes (CE/OE/WE) and the data-bus drive enable. Tri-state buffering stays in the top level.

---
 rtl/sram_arb.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_arb.sv
// Access sequencer and arbiter for the external 16-bit async SRAM: clear sweep, histogram RMW, USB readout.
// Optional build macro SRAM_INC_SAT_EN: increments saturate at 0xFFFF instead of wrapping.
module sram_arb #(
  parameter int unsigned ADR_W  = 20,
  parameter int unsigned T_RD   = 2,
  parameter int unsigned T_WR   = 2,
  parameter int unsigned FAIR_N = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CLR_START,
  output logic             CLR_BUSY,
  output logic             CLR_DONE,
  input  logic             INC_REQ,
  input  logic [ADR_W-1:0] INC_ADR,
  output logic             INC_ACK,
  input  logic             RD_REQ,
  input  logic [ADR_W-1:0] RD_ADR,
  output logic             RD_ACK,
  output logic [15:0]      RD_DATA,
  output logic [ADR_W-1:0] SRAM_A,
  input  logic [15:0]      SRAM_DI,
  output logic [15:0]      SRAM_DO,
  output logic             SRAM_DOE,
  output logic             SRAM_CE_N,
  output logic             SRAM_OE_N,
  output logic             SRAM_WE_N
);

  localparam int unsigned T_MAX = (T_RD > T_WR) ? T_RD : T_WR;
  localparam int unsigned CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int unsigned STK_W = (FAIR_N > 0) ? $clog2(FAIR_N + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADR, S_RDW, S_DONE, S_TURN, S_WRW, S_REC
  } state_e;

  typedef enum logic [1:0] {
    OP_RD, OP_INC, OP_CLR
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STK_W-1:0]   streak_q, streak_d;
  logic               clr_pend_q, clr_pend_d;
  logic               clr_busy_q, clr_busy_d;
  logic               clr_done_q, clr_done_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [15:0]        dout_q, dout_d;
  logic [15:0]        rd_data_q, rd_data_d;
  logic               doe_q, doe_d;
  logic               ce_n_q, ce_n_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic               rd_ack_q, rd_ack_d;
  logic               inc_ack_q, inc_ack_d;

  logic               clr_req;
  logic               inc_win;
  logic               rd_last;
  logic               wr_last;
  logic               adr_last;
  logic [15:0]        inc_val;

  // Next state, arbitration and registered-output values derived from the next state
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    clr_pend_d = clr_pend_q;
    clr_busy_d = clr_busy_q;
    adr_d      = adr_q;
    dout_d     = dout_q;
    rd_data_d  = rd_data_q;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    doe_d      = 1'b0;
    rd_ack_d   = 1'b0;
    inc_ack_d  = 1'b0;
    clr_done_d = 1'b0;

    clr_req  = clr_pend_q | (CLR_START & ~clr_busy_q);
    inc_win  = INC_REQ & ~(RD_REQ & (streak_q == STK_W'(FAIR_N)));
    rd_last  = (cnt_q == CNT_W'(T_RD - 1));
    wr_last  = (cnt_q == CNT_W'(T_WR - 1));
    adr_last = &adr_q;
`ifdef SRAM_INC_SAT_EN
    inc_val  = (&SRAM_DI) ? SRAM_DI : SRAM_DI + 16'd1;
`else
    inc_val  = SRAM_DI + 16'd1;
`endif

    // A start pulse is only accepted while no clear is pending or running
    if (CLR_START && !clr_busy_q) begin
      clr_busy_d = 1'b1;
      clr_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d    = S_ADR;
          op_d       = OP_CLR;
          adr_d      = '0;
          dout_d     = '0;
          clr_pend_d = 1'b0;
          if (!RD_REQ) streak_d = '0;
        end else if (inc_win) begin
          state_d  = S_ADR;
          op_d     = OP_INC;
          adr_d    = INC_ADR;
          streak_d = RD_REQ ? streak_q + STK_W'(1) : '0;
        end else if (RD_REQ) begin
          state_d  = S_ADR;
          op_d     = OP_RD;
          adr_d    = RD_ADR;
          streak_d = '0;
        end else begin
          streak_d = '0;
        end
      end
      S_ADR: begin
        cnt_d   = '0;
        state_d = (op_q == OP_CLR) ? S_WRW : S_RDW;
      end
      S_RDW: begin
        if (rd_last) begin
          cnt_d = '0;
          if (op_q == OP_RD) begin
            state_d   = S_DONE;
            rd_data_d = SRAM_DI;
          end else begin
            state_d = S_TURN;
            dout_d  = inc_val;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      S_TURN: begin
        cnt_d   = '0;
        state_d = S_WRW;
      end
      S_WRW: begin
        if (wr_last) begin
          cnt_d   = '0;
          state_d = S_REC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REC: begin
        // The clear sweep loops straight back to ADR until the top word is written
        if (op_q == OP_CLR && !adr_last) begin
          state_d = S_ADR;
          adr_d   = adr_q + ADR_W'(1);
        end else begin
          state_d = S_IDLE;
          if (op_q == OP_CLR) clr_busy_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_ADR: begin
        ce_n_d = 1'b0;
        doe_d  = (op_d == OP_CLR);
      end
      S_RDW: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      S_DONE: begin
        ce_n_d   = 1'b0;
        rd_ack_d = 1'b1;
      end
      S_TURN: begin
        ce_n_d = 1'b0;
        doe_d  = 1'b1;
      end
      S_WRW: begin
        ce_n_d = 1'b0;
        we_n_d = 1'b0;
        doe_d  = 1'b1;
      end
      S_REC: begin
        ce_n_d     = 1'b0;
        doe_d      = 1'b1;
        inc_ack_d  = (op_d == OP_INC);
        clr_done_d = (op_d == OP_CLR) && adr_last;
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any op with strobes released
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      op_q       <= OP_RD;
      cnt_q      <= '0;
      streak_q   <= '0;
      clr_pend_q <= 1'b0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
      adr_q      <= '0;
      dout_q     <= '0;
      rd_data_q  <= '0;
      doe_q      <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      rd_ack_q   <= 1'b0;
      inc_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      clr_pend_q <= clr_pend_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
      adr_q      <= adr_d;
      dout_q     <= dout_d;
      rd_data_q  <= rd_data_d;
      doe_q      <= doe_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      rd_ack_q   <= rd_ack_d;
      inc_ack_q  <= inc_ack_d;
    end
  end

  assign CLR_BUSY  = clr_busy_q;
  assign CLR_DONE  = clr_done_q;
  assign INC_ACK   = inc_ack_q;
  assign RD_ACK    = rd_ack_q;
  assign RD_DATA   = rd_data_q;
  assign SRAM_A    = adr_q;
  assign SRAM_DO   = dout_q;
  assign SRAM_DOE  = doe_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;

endmodule
